regfile_wb_scheduler: RTL and testbench
=======================================

// Module: regfile_wb_scheduler
// PURPOSE
//  Write-port scheduler and hazard scoreboard for the 4-entry register file. Shares the single
//  write port (ctrlRegWrite/writeReg/writeData) between the ALU and memory writeback paths.
//  Tracks pending destination registers and stalls issue on RAW/WAW hazards.
//  Sits between decode/issue, the two writeback sources and RegisterFiles.
// PARAMETERS
//  DATA_W    `WORD_SIZE (16)  writeback data width
//  NUM_REGS  `NUM_REGS (4)    register count
//  ADDR_W    2                register address width
//  FAIR      1                1 = round-robin on contention; 0 = fixed priority, memory path wins
// PORTS
//  clk            in   1       clock, all state on posedge
//  reset_n        in   1       asynchronous active-low reset
//  issue_valid    in   1       instruction presented for issue
//  issue_src1     in   ADDR_W  source register 1
//  issue_src2     in   ADDR_W  source register 2
//  issue_use_src1 in   1       src1 is read
//  issue_use_src2 in   1       src2 is read
//  issue_writes   in   1       instruction writes issue_dest
//  issue_dest     in   ADDR_W  destination register
//  issue_path     in   1       writeback path that will return dest (`PATH_ALU / `PATH_MEM)
//  issue_stall    out  1       issue blocked this cycle (combinational)
//  wba_valid/wba_reg/wba_data  in  1/ADDR_W/DATA_W  ALU writeback request
//  wba_ready      out  1       ALU writeback accepted this cycle
//  wbb_valid/wbb_reg/wbb_data  in  1/ADDR_W/DATA_W  memory writeback request
//  wbb_ready      out  1       memory writeback accepted this cycle
//  rf_write_en    out  1       drives RegisterFiles ctrlRegWrite (registered)
//  rf_write_reg   out  ADDR_W  drives writeReg (registered)
//  rf_write_data  out  DATA_W  drives writeData (registered)
//  wb_error       out  1       sticky: a writeback hit a non-pending register or the wrong path
// BEHAVIOUR
//  - Reset (async, reset_n=0): pending=0, owner=0, last_grant=`PATH_ALU, rf_write_en=0,
//    rf_write_reg=0, rf_write_data=0, wb_error=0. An in-flight write is dropped immediately.
//  - issue_stall = issue_valid & ((use_src1 & busy[src1]) | (use_src2 & busy[src2])
//    | (issue_writes & pending[dest])).
//    busy[r] = pending[r] | (rf_write_en & rf_write_reg==r).
//  - Issue accept (issue_valid & ~issue_stall & issue_writes): set pending[dest] and
//    owner[dest]=issue_path at the edge. Accepted issues carry at most one pending write per register.
//  - Arbitration: at most one accept per cycle; the write port never back-pressures.
//    Only one valid -> grant it. Both valid -> FAIR=1 grants the path != last_grant; FAIR=0 grants B.
//    last_grant updates on every accept. ready is combinational; a transfer is valid & ready.
//  - Accept at edge N: rf_write_en=1, reg and data registered for the cycle after N.
//    RegisterFiles commits at edge N+1. Without a new accept, rf_write_en returns to 0 after N+1.
//    Back-to-back accepts keep rf_write_en=1.
//  - Pending clear: at the accept edge, if pending[reg] & owner[reg]==path, pending[reg] is cleared.
//    Otherwise wb_error is set (sticky until reset), pending is unchanged and the write still goes out.
//  - Latency: wb accepted edge N -> a dependent reader can issue in the cycle after edge N+1
//    (covered by the rf_write_en match).
//  - Simultaneous set and clear of the same pending bit cannot occur, because the dest check stalls.
//    The bench asserts this never happens.
//  - Widths: no arithmetic; register indices are used directly. NUM_REGS == 2**ADDR_W.
// STRUCTURE
//  - opcodes.v gains `PATH_ALU 1'b0 and `PATH_MEM 1'b1; DATA_W and NUM_REGS come from
//    existing `WORD_SIZE / `NUM_REGS.
//  - One sub-module, wb_rr_arbiter: 2-way arbiter holding last_grant, with a FAIR parameter.
//  - Scoreboard (pending/owner vectors), output stage and error logic stay in the top module.
// TESTING
//  1. reset_n=0 while rf_write_en=1 -> rf_write_en=0 at once.
//     After release: wb_error=0, issue_stall=0 for src1=3.
//  2. Issue dest=2, path ALU; next cycle issue src1=2 -> stall=1.
//     wba r2 16'h1234 accepted at edge N -> rf_write_en=1, reg=2, data=1234.
//     Stall holds that cycle and clears the cycle after.
//  3. FAIR=1 after reset: wba and wbb valid together for 2 cycles -> cycle1 wbb_ready=1;
//     cycle2 wba_ready=1; rf writes B then A back-to-back.
//  4. FAIR=0: wbb valid every cycle, wba valid -> wba_ready stays 0 for 5 cycles.
//     It is granted the first cycle wbb drops.
//  5. wba to r3 with pending[3]=0, data 16'h00FF -> wb_error=1 and stays 1.
//     rf writes r3=00FF.
//  6. Issue dest=1 path MEM; then issue dest=1 -> stall=1.
//     wba r1 -> wb_error=1, pending[1] stays 1. wbb r1 -> pending[1] clears.

Source files
------------

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and helpers for the register-file writeback scheduler.
// Covers the writeback path encodings, the register-file geometry and one-hot decoding.
package regfile_wb_scheduler_pkg;

  localparam int   WORD_SIZE = 16;
  localparam int   NUM_REGS  = 4;
  localparam int   ADDR_W    = 2;
  localparam logic PATH_ALU  = 1'b0;
  localparam logic PATH_MEM  = 1'b1;

  // One-hot register mask, all-zero when en is low.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] idx, input logic en);
    logic [NUM_REGS-1:0] mask;
    mask = {NUM_REGS{1'b0}};
    mask[idx] = en;
    return mask;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_wb_rr_arbiter.sv
// Two-way writeback arbiter: A is the ALU path, B is the memory path.
// FAIR=1 alternates under contention; FAIR=0 always favours the memory path.
module wb_rr_arbiter
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req_a,
  input  logic req_b,
  output logic grant_a,
  output logic grant_b
);

  logic last_grant_r;

  // Grant decode; under contention the path that did not win last time goes first.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case ({req_a, req_b})
      2'b10: grant_a = 1'b1;
      2'b01: grant_b = 1'b1;
      2'b11: begin
        if (FAIR != 0) begin
          grant_a = (last_grant_r == PATH_MEM);
          grant_b = (last_grant_r == PATH_ALU);
        end else begin
          grant_b = 1'b1;
        end
      end
      default: begin
        grant_a = 1'b0;
        grant_b = 1'b0;
      end
    endcase
  end

  // Remember the most recent winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r <= PATH_ALU;
    end else if (grant_a || grant_b) begin
      last_grant_r <= grant_b ? PATH_MEM : PATH_ALU;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-port scheduler and hazard scoreboard for the register file.
// ALU and memory writebacks share one write port; pending destinations stall RAW/WAW issue.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int DATA_W   = WORD_SIZE,
  parameter int NUM_REGS = regfile_wb_scheduler_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_wb_scheduler_pkg::ADDR_W,
  parameter int FAIR     = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_src1,
  input  logic [ADDR_W-1:0] issue_src2,
  input  logic              issue_use_src1,
  input  logic              issue_use_src2,
  input  logic              issue_writes,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic              issue_path,
  output logic              issue_stall,
  input  logic              wba_valid,
  input  logic [ADDR_W-1:0] wba_reg,
  input  logic [DATA_W-1:0] wba_data,
  output logic              wba_ready,
  input  logic              wbb_valid,
  input  logic [ADDR_W-1:0] wbb_reg,
  input  logic [DATA_W-1:0] wbb_data,
  output logic              wbb_ready,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              wb_error
);

  logic [NUM_REGS-1:0] pending_r;
  logic [NUM_REGS-1:0] owner_r;
  logic [NUM_REGS-1:0] busy_s;
  logic [NUM_REGS-1:0] set_mask_s;
  logic [NUM_REGS-1:0] clr_mask_s;
  logic                issue_accept_s;
  logic                wb_fire_s;
  logic                wb_path_s;
  logic                wb_owned_s;
  logic [ADDR_W-1:0]   wb_reg_s;
  logic [DATA_W-1:0]   wb_data_s;

  wb_rr_arbiter #(.FAIR(FAIR)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req_a   (wba_valid),
    .req_b   (wbb_valid),
    .grant_a (wba_ready),
    .grant_b (wbb_ready)
  );

  // A register is busy while pending or while its final write is still on the port.
  always_comb begin
    busy_s = {NUM_REGS{1'b0}};
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_s[r] = pending_r[r] | (rf_write_en & (rf_write_reg == ADDR_W'(r)));
    end
  end

  assign issue_stall = issue_valid & ((issue_use_src1 & busy_s[issue_src1])
                                    | (issue_use_src2 & busy_s[issue_src2])
                                    | (issue_writes & pending_r[issue_dest]));
  assign issue_accept_s = issue_valid & ~issue_stall & issue_writes;

  assign wb_fire_s  = wba_ready | wbb_ready;
  assign wb_path_s  = wbb_ready ? PATH_MEM : PATH_ALU;
  assign wb_reg_s   = wbb_ready ? wbb_reg : wba_reg;
  assign wb_data_s  = wbb_ready ? wbb_data : wba_data;
  assign wb_owned_s = pending_r[wb_reg_s] & (owner_r[wb_reg_s] == wb_path_s);
  assign set_mask_s = reg_onehot(issue_dest, issue_accept_s);
  assign clr_mask_s = reg_onehot(wb_reg_s, wb_fire_s & wb_owned_s);

  // Scoreboard: issue sets pending/owner, a writeback from the owning path clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_r <= {NUM_REGS{1'b0}};
      owner_r   <= {NUM_REGS{1'b0}};
      wb_error  <= 1'b0;
    end else begin
      pending_r <= (pending_r & ~clr_mask_s) | set_mask_s;
      owner_r   <= (owner_r & ~set_mask_s) | (set_mask_s & {NUM_REGS{issue_path}});
      wb_error  <= wb_error | (wb_fire_s & ~wb_owned_s);
    end
  end

  // Registered write port; reg/data hold their last value while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_write_en   <= 1'b0;
      rf_write_reg  <= {ADDR_W{1'b0}};
      rf_write_data <= {DATA_W{1'b0}};
    end else if (wb_fire_s) begin
      rf_write_en   <= 1'b1;
      rf_write_reg  <= wb_reg_s;
      rf_write_data <= wb_data_s;
    end else begin
      rf_write_en   <= 1'b0;
      rf_write_reg  <= rf_write_reg;
      rf_write_data <= rf_write_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: FAIR=1 main instance with a write scoreboard,
// plus a FAIR=0 instance for fixed-priority arbitration.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [1:0]  issue_src1 = 2'd0;
  logic [1:0]  issue_src2 = 2'd0;
  logic        issue_use_src1 = 1'b0;
  logic        issue_use_src2 = 1'b0;
  logic        issue_writes = 1'b0;
  logic [1:0]  issue_dest = 2'd0;
  logic        issue_path = 1'b0;
  logic        issue_stall;
  logic        wba_valid = 1'b0;
  logic [1:0]  wba_reg = 2'd0;
  logic [15:0] wba_data = 16'h0000;
  logic        wba_ready;
  logic        wbb_valid = 1'b0;
  logic [1:0]  wbb_reg = 2'd0;
  logic [15:0] wbb_data = 16'h0000;
  logic        wbb_ready;
  logic        rf_write_en;
  logic [1:0]  rf_write_reg;
  logic [15:0] rf_write_data;
  logic        wb_error;

  logic        wba0_valid = 1'b0;
  logic        wbb0_valid = 1'b0;
  logic        wba0_ready, wbb0_ready, stall0, rf_en0, err0;
  logic [1:0]  rf_reg0;
  logic [15:0] rf_data0;

  int          checks = 0;
  int          failures = 0;
  logic        mon_en = 1'b0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_exp;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.FAIR(1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_src1(issue_src1), .issue_src2(issue_src2),
    .issue_use_src1(issue_use_src1), .issue_use_src2(issue_use_src2),
    .issue_writes(issue_writes), .issue_dest(issue_dest), .issue_path(issue_path),
    .issue_stall(issue_stall),
    .wba_valid(wba_valid), .wba_reg(wba_reg), .wba_data(wba_data), .wba_ready(wba_ready),
    .wbb_valid(wbb_valid), .wbb_reg(wbb_reg), .wbb_data(wbb_data), .wbb_ready(wbb_ready),
    .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .wb_error(wb_error)
  );

  regfile_wb_scheduler #(.FAIR(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(1'b0), .issue_src1(2'd0), .issue_src2(2'd0),
    .issue_use_src1(1'b0), .issue_use_src2(1'b0),
    .issue_writes(1'b0), .issue_dest(2'd0), .issue_path(1'b0),
    .issue_stall(stall0),
    .wba_valid(wba0_valid), .wba_reg(2'd2), .wba_data(16'h0A0A), .wba_ready(wba0_ready),
    .wbb_valid(wbb0_valid), .wbb_reg(2'd3), .wbb_data(16'h0B0B), .wbb_ready(wbb0_ready),
    .rf_write_en(rf_en0), .rf_write_reg(rf_reg0), .rf_write_data(rf_data0),
    .wb_error(err0)
  );

  // Scoreboard: every register-file write must match the next expected {reg,data}.
  always @(negedge clk) begin
    if (mon_en && reset_n && rf_write_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rf_write_unexpected got reg=%0d data=%h required no write", rf_write_reg, rf_write_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rf_write_reg, rf_write_data} !== mon_exp) begin
          failures++;
          $display("FAIL rf_write got reg=%0d data=%h required reg=%0d data=%h",
                   rf_write_reg, rf_write_data, mon_exp[17:16], mon_exp[15:0]);
        end
      end
    end
  end

  // A pending bit must never be set and cleared in the same cycle.
  always @(negedge clk) begin
    if (reset_n && issue_valid && !issue_stall && issue_writes && (wba_ready || wbb_ready)) begin
      checks++;
      if (issue_dest == (wbb_ready ? wbb_reg : wba_reg)) begin
        failures++;
        $display("FAIL set_clear_same_bit got dest=%0d required dest != wb reg", issue_dest);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({rf_write_en, rf_write_reg, rf_write_data, wb_error} !== 20'h0) begin
      failures++;
      $display("FAIL reset_state got en=%b reg=%0d data=%h err=%b required all zero",
               rf_write_en, rf_write_reg, rf_write_data, wb_error);
    end
    reset_n = 1'b1;
    tick();
    wba_valid = 1'b1; wba_reg = 2'd0; wba_data = 16'hBEEF;
    tick();
    wba_valid = 1'b0;
    checks++;
    if (rf_write_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_inflight_setup got en=%b required 1", rf_write_en);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (rf_write_en !== 1'b0 || wb_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_drops_write got en=%b err=%b required 0 0", rf_write_en, wb_error);
    end
    tick();
    reset_n = 1'b1;
    tick();
    issue_valid = 1'b1; issue_src1 = 2'd3; issue_use_src1 = 1'b1;
    #1;
    checks++;
    if (issue_stall !== 1'b0 || wb_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got stall=%b err=%b required 0 0", issue_stall, wb_error);
    end
    issue_valid = 1'b0; issue_use_src1 = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_raw_hazard();
    issue_valid = 1'b1; issue_writes = 1'b1; issue_dest = 2'd2; issue_path = 1'b0;
    tick();
    issue_writes = 1'b0; issue_src1 = 2'd2; issue_use_src1 = 1'b1;
    wba_valid = 1'b1; wba_reg = 2'd2; wba_data = 16'h1234;
    exp_q.push_back({2'd2, 16'h1234});
    #1;
    checks++;
    if (issue_stall !== 1'b1 || wba_ready !== 1'b1) begin
      failures++;
      $display("FAIL raw_pending got stall=%b wba_ready=%b required 1 1", issue_stall, wba_ready);
    end
    tick();
    wba_valid = 1'b0;
    #1;
    checks++;
    if (rf_write_en !== 1'b1 || rf_write_reg !== 2'd2 || rf_write_data !== 16'h1234 || issue_stall !== 1'b1) begin
      failures++;
      $display("FAIL raw_write_cycle got en=%b reg=%0d data=%h stall=%b required 1 2 1234 1",
               rf_write_en, rf_write_reg, rf_write_data, issue_stall);
    end
    tick();
    checks++;
    if (issue_stall !== 1'b0 || rf_write_en !== 1'b0 || wb_error !== 1'b0) begin
      failures++;
      $display("FAIL raw_release got stall=%b en=%b err=%b required 0 0 0", issue_stall, rf_write_en, wb_error);
    end
    issue_valid = 1'b0; issue_use_src1 = 1'b0;
  endtask

  task automatic test_fair_arb();
    issue_valid = 1'b1; issue_writes = 1'b1; issue_dest = 2'd0; issue_path = 1'b0;
    tick();
    issue_dest = 2'd1; issue_path = 1'b1;
    tick();
    issue_valid = 1'b0; issue_writes = 1'b0;
    wba_valid = 1'b1; wba_reg = 2'd0; wba_data = 16'hAAAA;
    wbb_valid = 1'b1; wbb_reg = 2'd1; wbb_data = 16'hBBBB;
    exp_q.push_back({2'd1, 16'hBBBB});
    #1;
    checks++;
    if (wbb_ready !== 1'b1 || wba_ready !== 1'b0) begin
      failures++;
      $display("FAIL fair_cycle1 got a=%b b=%b required 0 1", wba_ready, wbb_ready);
    end
    tick();
    exp_q.push_back({2'd0, 16'hAAAA});
    checks++;
    if (wba_ready !== 1'b1 || wbb_ready !== 1'b0 || rf_write_reg !== 2'd1 || rf_write_data !== 16'hBBBB) begin
      failures++;
      $display("FAIL fair_cycle2 got a=%b b=%b reg=%0d data=%h required 1 0 1 BBBB",
               wba_ready, wbb_ready, rf_write_reg, rf_write_data);
    end
    tick();
    wba_valid = 1'b0; wbb_valid = 1'b0;
    #1;
    checks++;
    if (rf_write_en !== 1'b1 || rf_write_reg !== 2'd0 || rf_write_data !== 16'hAAAA) begin
      failures++;
      $display("FAIL fair_back_to_back got en=%b reg=%0d data=%h required 1 0 AAAA",
               rf_write_en, rf_write_reg, rf_write_data);
    end
    tick();
    checks++;
    if (rf_write_en !== 1'b0 || wb_error !== 1'b0) begin
      failures++;
      $display("FAIL fair_idle got en=%b err=%b required 0 0", rf_write_en, wb_error);
    end
  endtask

  task automatic test_fixed_priority();
    wba0_valid = 1'b1; wbb0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (wba0_ready !== 1'b0 || wbb0_ready !== 1'b1) begin
        failures++;
        $display("FAIL fixed_prio cycle=%0d got a=%b b=%b required 0 1", i, wba0_ready, wbb0_ready);
      end
      tick();
    end
    wbb0_valid = 1'b0;
    #1;
    checks++;
    if (wba0_ready !== 1'b1) begin
      failures++;
      $display("FAIL fixed_prio_release got a=%b required 1", wba0_ready);
    end
    tick();
    wba0_valid = 1'b0;
  endtask

  task automatic test_stray_write();
    wba_valid = 1'b1; wba_reg = 2'd3; wba_data = 16'h00FF;
    exp_q.push_back({2'd3, 16'h00FF});
    tick();
    wba_valid = 1'b0;
    checks++;
    if (wb_error !== 1'b1 || rf_write_reg !== 2'd3 || rf_write_data !== 16'h00FF) begin
      failures++;
      $display("FAIL stray_write got err=%b reg=%0d data=%h required 1 3 00FF", wb_error, rf_write_reg, rf_write_data);
    end
    tick();
    tick();
    checks++;
    if (wb_error !== 1'b1) begin
      failures++;
      $display("FAIL error_sticky got err=%b required 1", wb_error);
    end
  endtask

  task automatic test_wrong_path();
    apply_reset();
    issue_valid = 1'b1; issue_writes = 1'b1; issue_dest = 2'd1; issue_path = 1'b1;
    tick();
    #1;
    checks++;
    if (issue_stall !== 1'b1 || wb_error !== 1'b0) begin
      failures++;
      $display("FAIL waw_stall got stall=%b err=%b required 1 0", issue_stall, wb_error);
    end
    issue_valid = 1'b0;
    wba_valid = 1'b1; wba_reg = 2'd1; wba_data = 16'h1111;
    exp_q.push_back({2'd1, 16'h1111});
    tick();
    wba_valid = 1'b0;
    tick();
    issue_valid = 1'b1;
    #1;
    checks++;
    if (wb_error !== 1'b1 || issue_stall !== 1'b1) begin
      failures++;
      $display("FAIL wrong_path got err=%b stall=%b required 1 1", wb_error, issue_stall);
    end
    issue_valid = 1'b0;
    wbb_valid = 1'b1; wbb_reg = 2'd1; wbb_data = 16'h2222;
    exp_q.push_back({2'd1, 16'h2222});
    tick();
    wbb_valid = 1'b0;
    issue_valid = 1'b1;
    #1;
    checks++;
    if (issue_stall !== 1'b0 || rf_write_data !== 16'h2222) begin
      failures++;
      $display("FAIL owner_clears got stall=%b data=%h required 0 2222", issue_stall, rf_write_data);
    end
    issue_valid = 1'b0; issue_writes = 1'b0;
  endtask

  initial begin
    test_reset();
    test_raw_hazard();
    test_fair_arb();
    test_fixed_priority();
    test_stray_write();
    test_wrong_path();
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d left required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
